// File: rtl/ace_snoop_responder_if.sv
// ace_snoop_responder_if: AC/CR/CD snoop channels plus cache lookup/update ports of the snoop responder.
interface ace_snoop_responder_if #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineWidth = 512
);
   logic                 ac_valid_i;
   logic                 ac_ready_o;
   logic [AddrWidth-1:0] ac_addr_i;
   logic [3:0]           ac_snoop_i;
   logic [2:0]           ac_prot_i;
   logic                 cr_valid_o;
   logic                 cr_ready_i;
   logic [4:0]           cr_resp_o;
   logic                 cd_valid_o;
   logic                 cd_ready_i;
   logic [DataWidth-1:0] cd_data_o;
   logic                 cd_last_o;
   logic                 lookup_req_o;
   logic [AddrWidth-1:0] lookup_addr_o;
   logic                 lookup_gnt_i;
   logic                 lookup_hit_i;
   logic                 lookup_dirty_i;
   logic                 lookup_shared_i;
   logic [LineWidth-1:0] line_data_i;
   logic                 update_req_o;
   logic [1:0]           update_op_o;
   logic                 update_gnt_i;
   modport slave (
      input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
             lookup_gnt_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, line_data_i, update_gnt_i,
      output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
             lookup_req_o, lookup_addr_o, update_req_o, update_op_o
   );
   modport master (
      output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
             lookup_gnt_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, line_data_i, update_gnt_i,
      input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
             lookup_req_o, lookup_addr_o, update_req_o, update_op_o
   );
endinterface

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: one-at-a-time ACE snoop handler (lookup, state update, CR response, CD line beats).
// Define SNOOP_RSP_PARALLEL_CD_EN to drive CR and CD concurrently instead of CD after the CR handshake.
module ace_snoop_responder #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineWidth = 512
) (
   input logic clk_i,
   input logic rst_ni,
   ace_snoop_responder_if.slave bus
);
   localparam int Beats = LineWidth / DataWidth;
   localparam int BW = Beats > 1 ? $clog2(Beats) : 1;
   if (LineWidth % DataWidth != 0 || LineWidth < DataWidth) begin : g_chk
      $error("LineWidth must be a non-zero multiple of DataWidth");
   end
   typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, RESP, DATA, RESP_DATA} state_t;
   state_t               state;
   logic [AddrWidth-1:0] addr;
   logic [3:0]           snoop;
   logic [2:0]           unused_prot;
   logic [LineWidth-1:0] line;
   logic [4:0]           rsp, lk_rsp, rsp_next;
   logic [1:0]           lk_op, d_op;
   logic [BW-1:0]        beat, nbeat;
   logic rd_once, rd_sh, rd_un, cl_sh, mk_inv, d_dt, d_pd, d_is, supported, go_resp;
   always_comb begin
      rd_once = snoop == 4'b0000;
      rd_sh = snoop inside {4'b0001, 4'b0010, 4'b0011};
      rd_un = snoop inside {4'b0111, 4'b1001};
      cl_sh = snoop == 4'b1000;
      mk_inv = snoop == 4'b1101;
      d_dt = rd_once | rd_sh | rd_un | (cl_sh & bus.lookup_dirty_i);
      d_pd = (rd_sh | rd_un | cl_sh) & bus.lookup_dirty_i;
      d_is = rd_once | rd_sh | cl_sh;
      d_op = (rd_un | mk_inv) ? 2'b01 : (rd_sh | (cl_sh & bus.lookup_dirty_i)) ? 2'b10 : 2'b00;
      lk_rsp = bus.lookup_hit_i ? {!bus.lookup_shared_i, d_is, d_pd, 1'b0, d_dt} : 5'b00000;
      lk_op = bus.lookup_hit_i ? d_op : 2'b00;
      supported = bus.ac_snoop_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};
      nbeat = beat + 1'b1;
      go_resp = (state == IDLE && bus.ac_valid_i && !supported) ||
                (state == LOOKUP && bus.lookup_gnt_i && lk_op == 2'b00) ||
                (state == UPDATE && bus.update_gnt_i);
      rsp_next = state == IDLE ? 5'b00010 : state == LOOKUP ? lk_rsp : rsp;
   end
   assign bus.lookup_addr_o = addr;
`ifdef SNOOP_RSP_PARALLEL_CD_EN
   logic [LineWidth-1:0] line_src;
   logic cr_done, cd_done, cr_fin, cd_fin;
   always_comb begin
      line_src = state == LOOKUP ? bus.line_data_i : line;
      cr_fin = cr_done | (bus.cr_valid_o & bus.cr_ready_i);
      cd_fin = cd_done | (bus.cd_valid_o & bus.cd_ready_i & bus.cd_last_o);
   end
`endif
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         addr <= '0;
         snoop <= '0;
         unused_prot <= '0;
         line <= '0;
         rsp <= '0;
         beat <= '0;
         bus.ac_ready_o <= 1'b1;
         bus.lookup_req_o <= 1'b0;
         bus.update_req_o <= 1'b0;
         bus.update_op_o <= 2'b00;
         bus.cr_valid_o <= 1'b0;
         bus.cr_resp_o <= '0;
         bus.cd_valid_o <= 1'b0;
         bus.cd_data_o <= '0;
         bus.cd_last_o <= 1'b0;
`ifdef SNOOP_RSP_PARALLEL_CD_EN
         cr_done <= 1'b0;
         cd_done <= 1'b0;
`endif
      end else begin
         if (bus.cr_valid_o && bus.cr_ready_i) begin
            bus.cr_valid_o <= 1'b0;
            bus.cr_resp_o <= '0;
         end
         // Beats go out in line order; the counter returns to 0 with the last handshake.
         if (bus.cd_valid_o && bus.cd_ready_i) begin
            if (bus.cd_last_o) begin
               bus.cd_valid_o <= 1'b0;
               bus.cd_last_o <= 1'b0;
               bus.cd_data_o <= '0;
               beat <= '0;
            end else begin
               beat <= nbeat;
               bus.cd_data_o <= line[int'(nbeat) * DataWidth +: DataWidth];
               bus.cd_last_o <= nbeat == BW'(Beats - 1);
            end
         end
         case (state)
            IDLE: if (bus.ac_valid_i) begin
               bus.ac_ready_o <= 1'b0;
               addr <= bus.ac_addr_i;
               snoop <= bus.ac_snoop_i;
               unused_prot <= bus.ac_prot_i;
               if (supported) begin
                  state <= LOOKUP;
                  bus.lookup_req_o <= 1'b1;
               end
            end
            LOOKUP: if (bus.lookup_gnt_i) begin
               bus.lookup_req_o <= 1'b0;
               line <= bus.line_data_i;
               rsp <= lk_rsp;
               if (lk_op != 2'b00) begin
                  state <= UPDATE;
                  bus.update_req_o <= 1'b1;
                  bus.update_op_o <= lk_op;
               end
            end
            UPDATE: if (bus.update_gnt_i) begin
               bus.update_req_o <= 1'b0;
               bus.update_op_o <= 2'b00;
            end
            RESP: if (bus.cr_ready_i) begin
               if (rsp[0]) begin
                  state <= DATA;
                  bus.cd_valid_o <= 1'b1;
                  bus.cd_data_o <= line[0 +: DataWidth];
                  bus.cd_last_o <= Beats == 1;
               end else begin
                  state <= IDLE;
                  bus.ac_ready_o <= 1'b1;
               end
            end
            DATA: if (bus.cd_ready_i && bus.cd_last_o) begin
               state <= IDLE;
               bus.ac_ready_o <= 1'b1;
            end
`ifdef SNOOP_RSP_PARALLEL_CD_EN
            RESP_DATA: begin
               cr_done <= cr_fin;
               cd_done <= cd_fin;
               if (cr_fin && cd_fin) begin
                  state <= IDLE;
                  bus.ac_ready_o <= 1'b1;
                  cr_done <= 1'b0;
                  cd_done <= 1'b0;
               end
            end
`endif
            default: state <= IDLE;
         endcase
         if (go_resp) begin
            rsp <= rsp_next;
            bus.cr_valid_o <= 1'b1;
            bus.cr_resp_o <= rsp_next;
            state <= RESP;
`ifdef SNOOP_RSP_PARALLEL_CD_EN
            if (rsp_next[0]) begin
               state <= RESP_DATA;
               bus.cd_valid_o <= 1'b1;
               bus.cd_data_o <= line_src[0 +: DataWidth];
               bus.cd_last_o <= Beats == 1;
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed snoop scenarios with hand-computed CR/CD/update expectations.
module tb_ace_snoop_responder;
   localparam int AW = 64, DW = 64, LW = 512, NB = LW / DW;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0, errors = 0;
   int upd_seen = 0, lk_seen = 0, cdv_seen = 0, overlap = 0;
   ace_snoop_responder_if #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) bus();
   ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.update_req_o) upd_seen++;
      if (bus.lookup_req_o) lk_seen++;
      if (bus.cd_valid_o) cdv_seen++;
      if (bus.cd_valid_o && bus.cr_valid_o) overlap++;
   end
   function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
      logic [LW-1:0] l;
      for (int k = 0; k < NB; k++) l[k*DW +: DW] = {seed, 32'(k)};
      return l;
   endfunction
   task automatic idle_inputs();
      bus.ac_valid_i = 0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0; bus.ac_prot_i = '0;
      bus.cr_ready_i = 0; bus.cd_ready_i = 0; bus.lookup_gnt_i = 0; bus.lookup_hit_i = 0;
      bus.lookup_dirty_i = 0; bus.lookup_shared_i = 0; bus.line_data_i = '0; bus.update_gnt_i = 0;
   endtask
   task automatic snoop_txn(input string name, input logic [3:0] snp, input logic hit, input logic dirty,
                            input logic shared, input logic [31:0] seed, input logic [4:0] exp_resp,
                            input logic [1:0] exp_op, input int exp_beats, input int cr_stall,
                            input bit toggle_cd, input int abort_beat);
      logic [AW-1:0] a;
      logic [DW-1:0] exp_d;
      bit exp_lookup;
      int n;
      a = {32'h8000_0000, seed};
      exp_lookup = exp_resp != 5'b00010;
      @(negedge clk);
      upd_seen = 0; lk_seen = 0; cdv_seen = 0; overlap = 0;
      checks++;
      if (bus.ac_ready_o !== 1'b1) begin errors++; $display("FAIL %s ac_ready_idle: got %b expected 1", name, bus.ac_ready_o); end
      bus.ac_valid_i = 1; bus.ac_addr_i = a; bus.ac_snoop_i = snp; bus.ac_prot_i = 3'b010;
      @(negedge clk);
      bus.ac_valid_i = 0;
      checks++;
      if (bus.ac_ready_o !== 1'b0) begin errors++; $display("FAIL %s ac_ready_busy: got %b expected 0", name, bus.ac_ready_o); end
      if (exp_lookup) begin
         checks++;
         if (bus.lookup_req_o !== 1'b1 || bus.lookup_addr_o !== a)
            begin errors++; $display("FAIL %s lookup_req: got %b/%h expected 1/%h", name, bus.lookup_req_o, bus.lookup_addr_o, a); end
         @(negedge clk);
         checks++;
         if (bus.lookup_req_o !== 1'b1) begin errors++; $display("FAIL %s lookup_hold: got %b expected 1", name, bus.lookup_req_o); end
         bus.lookup_gnt_i = 1; bus.lookup_hit_i = hit; bus.lookup_dirty_i = dirty;
         bus.lookup_shared_i = shared; bus.line_data_i = mk_line(seed);
         @(negedge clk);
         bus.lookup_gnt_i = 0; bus.lookup_hit_i = 0; bus.lookup_dirty_i = 0; bus.lookup_shared_i = 0; bus.line_data_i = '0;
         checks++;
         if (bus.lookup_req_o !== 1'b0) begin errors++; $display("FAIL %s lookup_drop: got %b expected 0", name, bus.lookup_req_o); end
      end
      if (exp_op != 2'b00) begin
         n = 0;
         while (bus.update_req_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         checks++;
         if (bus.update_req_o !== 1'b1 || bus.update_op_o !== exp_op)
            begin errors++; $display("FAIL %s update: got %b/%b expected 1/%b", name, bus.update_req_o, bus.update_op_o, exp_op); end
         @(negedge clk);
         checks++;
         if (bus.update_req_o !== 1'b1 || bus.update_op_o !== exp_op)
            begin errors++; $display("FAIL %s update_hold: got %b/%b expected 1/%b", name, bus.update_req_o, bus.update_op_o, exp_op); end
         bus.update_gnt_i = 1;
         @(negedge clk);
         bus.update_gnt_i = 0;
      end
      n = 0;
      while (bus.cr_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.cr_valid_o !== 1'b1 || bus.cr_resp_o !== exp_resp)
         begin errors++; $display("FAIL %s cr_resp: got %b/%b expected 1/%b", name, bus.cr_valid_o, bus.cr_resp_o, exp_resp); end
      for (int i = 0; i < cr_stall; i++) begin
         @(negedge clk);
         checks++;
         if (bus.cr_valid_o !== 1'b1 || bus.cr_resp_o !== exp_resp || bus.ac_ready_o !== 1'b0)
            begin errors++; $display("FAIL %s cr_stall: got %b/%b/%b expected 1/%b/0", name, bus.cr_valid_o, bus.cr_resp_o, bus.ac_ready_o, exp_resp); end
      end
      bus.cr_ready_i = 1;
      @(negedge clk);
      bus.cr_ready_i = 0;
      checks++;
      if (bus.cr_valid_o !== 1'b0 || bus.ac_ready_o !== (exp_beats == 0))
         begin errors++; $display("FAIL %s cr_done: got %b/%b expected 0/%b", name, bus.cr_valid_o, bus.ac_ready_o, exp_beats == 0); end
      for (int k = 0; k < exp_beats; k++) begin
         exp_d = {seed, 32'(k)};
         n = 0;
         while (bus.cd_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         checks++;
         if (bus.cd_valid_o !== 1'b1 || bus.cd_data_o !== exp_d || bus.cd_last_o !== (k == exp_beats - 1) || bus.ac_ready_o !== 1'b0)
            begin errors++; $display("FAIL %s cd_beat%0d: got %b/%h/%b/%b expected 1/%h/%b/0", name, k, bus.cd_valid_o, bus.cd_data_o, bus.cd_last_o, bus.ac_ready_o, exp_d, k == exp_beats - 1); end
         if (k == abort_beat) begin
            #2 rst_n = 0;
            #1;
            checks++;
            if (bus.cd_valid_o !== 1'b0 || bus.cr_valid_o !== 1'b0 || bus.ac_ready_o !== 1'b1 || bus.lookup_req_o !== 1'b0)
               begin errors++; $display("FAIL %s async_reset: got cd=%b cr=%b ac_ready=%b lk=%b expected 0/0/1/0", name, bus.cd_valid_o, bus.cr_valid_o, bus.ac_ready_o, bus.lookup_req_o); end
            @(negedge clk);
            rst_n = 1;
            return;
         end
         if (toggle_cd && k % 2 == 1) begin
            @(negedge clk);
            checks++;
            if (bus.cd_valid_o !== 1'b1 || bus.cd_data_o !== exp_d)
               begin errors++; $display("FAIL %s cd_stall%0d: got %b/%h expected 1/%h", name, k, bus.cd_valid_o, bus.cd_data_o, exp_d); end
         end
         bus.cd_ready_i = 1;
         @(negedge clk);
         bus.cd_ready_i = 0;
      end
      checks++;
      if (bus.ac_ready_o !== 1'b1 || bus.cd_valid_o !== 1'b0)
         begin errors++; $display("FAIL %s end_idle: got ac_ready=%b cd_valid=%b expected 1/0", name, bus.ac_ready_o, bus.cd_valid_o); end
      if (exp_op == 2'b00) begin
         checks++;
         if (upd_seen != 0) begin errors++; $display("FAIL %s no_update: got %0d cycles expected 0", name, upd_seen); end
      end
      if (!exp_lookup) begin
         checks++;
         if (lk_seen != 0) begin errors++; $display("FAIL %s no_lookup: got %0d cycles expected 0", name, lk_seen); end
      end
      if (exp_beats == 0) begin
         checks++;
         if (cdv_seen != 0) begin errors++; $display("FAIL %s no_cd: got %0d cycles expected 0", name, cdv_seen); end
      end
`ifndef SNOOP_RSP_PARALLEL_CD_EN
      checks++;
      if (overlap != 0) begin errors++; $display("FAIL %s cr_cd_overlap: got %0d cycles expected 0", name, overlap); end
`endif
   endtask
   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ac_ready_o !== 1'b1 || bus.cr_valid_o !== 1'b0 || bus.cd_valid_o !== 1'b0 || bus.lookup_req_o !== 1'b0 ||
          bus.update_req_o !== 1'b0 || bus.cr_resp_o !== 5'b0 || bus.update_op_o !== 2'b0 || bus.cd_last_o !== 1'b0)
         begin errors++; $display("FAIL reset_state: got ac_ready=%b cr=%b cd=%b lk=%b upd=%b resp=%b op=%b last=%b", bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.lookup_req_o, bus.update_req_o, bus.cr_resp_o, bus.update_op_o, bus.cd_last_o); end
      rst_n = 1;
   endtask
   task automatic test_read_shared();
      snoop_txn("read_shared_dirty", 4'b0001, 1, 1, 1, 32'h0, 5'b01101, 2'b10, NB, 0, 0, -1);
   endtask
   task automatic test_read_unique();
      snoop_txn("read_unique_clean", 4'b0111, 1, 0, 0, 32'h1111, 5'b10001, 2'b01, NB, 0, 0, -1);
   endtask
   task automatic test_make_invalid();
      snoop_txn("make_invalid_dirty", 4'b1101, 1, 1, 0, 32'h2222, 5'b10000, 2'b01, 0, 0, 0, -1);
   endtask
   task automatic test_miss();
      snoop_txn("read_shared_miss", 4'b0001, 0, 1, 0, 32'h3333, 5'b00000, 2'b00, 0, 0, 0, -1);
      snoop_txn("read_unique_miss", 4'b0111, 0, 0, 0, 32'h3334, 5'b00000, 2'b00, 0, 0, 0, -1);
   endtask
   task automatic test_unsupported();
      snoop_txn("unsupported_0101", 4'b0101, 1, 1, 0, 32'h4444, 5'b00010, 2'b00, 0, 0, 0, -1);
   endtask
   task automatic test_clean_shared();
      snoop_txn("clean_shared_clean", 4'b1000, 1, 0, 1, 32'h5555, 5'b01000, 2'b00, 0, 0, 0, -1);
      snoop_txn("clean_shared_dirty", 4'b1000, 1, 1, 0, 32'h5556, 5'b11101, 2'b10, NB, 0, 0, -1);
   endtask
   task automatic test_stall();
      snoop_txn("read_clean_stall", 4'b0010, 1, 0, 0, 32'h6666, 5'b11001, 2'b10, NB, 5, 1, -1);
   endtask
   task automatic test_reset_mid_beat();
      snoop_txn("read_once_abort", 4'b0000, 1, 0, 0, 32'h7777, 5'b11001, 2'b00, NB, 0, 0, 3);
      idle_inputs();
      snoop_txn("read_once_after_reset", 4'b0000, 1, 0, 0, 32'h7778, 5'b11001, 2'b00, NB, 0, 0, -1);
   endtask
   task automatic test_back_to_back();
      snoop_txn("b2b_clean_invalid", 4'b1001, 1, 1, 1, 32'h8888, 5'b00101, 2'b01, NB, 0, 0, -1);
      snoop_txn("b2b_read_not_shared_dirty", 4'b0011, 1, 0, 1, 32'h8889, 5'b01001, 2'b10, NB, 1, 1, -1);
   endtask
   initial begin
      test_reset();
      test_read_shared();
      test_read_unique();
      test_make_invalid();
      test_miss();
      test_unsupported();
      test_clean_shared();
      test_stall();
      test_reset_mid_beat();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
